// File: rtl/dense_mac.sv
// Sequencer and six-lane multiply-accumulate engine for one dense layer.
// Walks the weight ROM and the input buffer, then emits each saturated group of neurons.
module dense_mac #(
  parameter int N_IN   = 200,
  parameter int N_OUT  = 24,
  parameter int LANES  = 6,
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 10,
  parameter int X_AW   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [LANES*DW-1:0]   rom_q,
  output logic [X_AW-1:0]       x_addr,
  input  logic [DW-1:0]         x_q,
  output logic                  busy,
  output logic                  y_valid,
  output logic [LANES*DW-1:0]   y_data,
  output logic [((N_OUT/LANES) > 1 ? $clog2(N_OUT/LANES) : 1)-1:0] y_group,
  output logic                  done
);

  // state  | meaning
  // IDLE   | waiting for run; outputs hold
  // RUN    | issuing addresses, accumulating, emitting one group per period
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int G_N = N_OUT / LANES;
  localparam int GW  = (G_N > 1) ? $clog2(G_N) : 1;
  localparam int CW  = $clog2(N_IN + 2);

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(1 << (DW - 1)));

  logic [0:0]              state;
  logic [GW-1:0]           g;
  logic [CW-1:0]           tmr;
  logic                    v1, v2;
  logic signed [ACC_W-1:0] acc      [LANES];
  logic signed [ACC_W-1:0] prod_ext [LANES];
  logic [LANES*DW-1:0]     y_next;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] sh;
    assign prod        = $signed(rom_q[DW*j +: DW]) * $signed(x_q);
    assign prod_ext[j] = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign sh          = acc[j] >>> FRAC;
    assign y_next[DW*j +: DW] = (sh > Y_MAX) ? Y_MAX[DW-1:0] :
                                (sh < Y_MIN) ? Y_MIN[DW-1:0] : sh[DW-1:0];
  end

  // tmr counts down the group period; reaching zero marks the emit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      g        <= '0;
      tmr      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      rom_addr <= '0;
      x_addr   <= '0;
      busy     <= 1'b0;
      y_valid  <= 1'b0;
      y_data   <= '0;
      y_group  <= '0;
      done     <= 1'b0;
      for (int j = 0; j < LANES; j++) acc[j] <= '0;
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      v2      <= v1;
      case (state)
        S_IDLE: begin
          v1 <= 1'b0;
          if (run) begin
            state    <= S_RUN;
            g        <= '0;
            rom_addr <= '0;
            x_addr   <= '0;
            tmr      <= CW'(N_IN + 1);
            v1       <= 1'b1;
            busy     <= 1'b1;
            for (int j = 0; j < LANES; j++) acc[j] <= '0;
          end
        end
        default: begin
          if (v2) begin
            for (int j = 0; j < LANES; j++) acc[j] <= acc[j] + prod_ext[j];
          end
          if (tmr == '0) begin
            y_data  <= y_next;
            y_group <= g;
            y_valid <= 1'b1;
            for (int j = 0; j < LANES; j++) acc[j] <= '0;
            if (g == GW'(G_N - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
              v1    <= 1'b0;
            end else begin
              // rom_addr holds at the group's last word, so +1 is the next group's base
              g        <= g + 1'b1;
              rom_addr <= rom_addr + 1'b1;
              x_addr   <= '0;
              tmr      <= CW'(N_IN + 1);
              v1       <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
            if (x_addr != X_AW'(N_IN - 1)) begin
              x_addr   <= x_addr + 1'b1;
              rom_addr <= rom_addr + 1'b1;
              v1       <= 1'b1;
            end else begin
              v1 <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac.sv
// Randomized scoreboard bench for dense_mac with synchronous-read ROM and input buffer models.
module tb_dense_mac;
  localparam int N_IN = 200, N_OUT = 24, LANES = 6, DW = 16;
  localparam int G_N = N_OUT / LANES;
  localparam int PER = N_IN + 2;

  logic              clk = 1'b0;
  logic              rst, run;
  logic [9:0]        rom_addr;
  logic [95:0]       rom_q;
  logic [7:0]        x_addr;
  logic [15:0]       x_q;
  logic              busy, y_valid, done;
  logic [95:0]       y_data;
  logic [1:0]        y_group;

  logic [95:0] rom  [1024];
  logic [15:0] xbuf [256];

  typedef struct {
    logic [95:0] data;
    int          grp;
    bit          last;
    longint      cyc;
  } exp_t;
  exp_t sb[$];

  int     checks = 0, errors = 0;
  longint cyc = 0, run_cyc = 0;
  int     max_addr;

  dense_mac dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_q(rom_q),
    .x_addr(x_addr), .x_q(x_q), .busy(busy), .y_valid(y_valid),
    .y_data(y_data), .y_group(y_group), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom[rom_addr];
    x_q   <= xbuf[x_addr];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill(input int mode);
    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < LANES; j++) begin
        case (mode)
          0: rom[a][16*j +: 16] = 16'h0100;
          1: rom[a][16*j +: 16] = 16'(j * 256);
          2: rom[a][16*j +: 16] = 16'h8000;
          3: rom[a][16*j +: 16] = 16'h7FFF;
          default: rom[a][16*j +: 16] = 16'($urandom);
        endcase
      end
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0, 1: xbuf[i] = 16'h0001;
        2, 3: xbuf[i] = 16'h7FFF;
        default: xbuf[i] = 16'($urandom);
      endcase
    end
  endtask

  // Reference: full-precision dot product, floor-scaled by 2^8, clamped to int16.
  task automatic push_expected();
    for (int g = 0; g < G_N; g++) begin
      exp_t e;
      e.data = '0;
      for (int j = 0; j < LANES; j++) begin
        longint s = 0, qv;
        logic [15:0] w;
        for (int i = 0; i < N_IN; i++) begin
          w = rom[g*N_IN + i][16*j +: 16];
          s += longint'($signed(w)) * longint'($signed(xbuf[i]));
        end
        qv = (s >= 0) ? s / 256 : -((-s + 255) / 256);
        if (qv > 32767) qv = 32767;
        if (qv < -32768) qv = -32768;
        e.data[16*j +: 16] = 16'(qv);
      end
      e.grp  = g;
      e.last = (g == G_N - 1);
      e.cyc  = run_cyc + longint'((g + 1) * PER);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (y_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_y_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("y_data", y_data, e.data);
          check("y_group", y_group, e.grp);
          check("done_with_valid", done, e.last);
          check("y_valid_cycle", cyc, e.cyc);
        end
      end else if (done) begin
        check("done_without_valid", 1, 0);
      end
    end
  end

  task automatic check_zero_outputs(input string name);
    check(name, {rom_addr, x_addr, busy, y_valid, y_data, y_group, done}, '0);
  endtask

  // abort_at < 0 means no reset mid-pass
  task automatic run_pass(input int mode, input bit chk_addr, input bit pulse, input int abort_at);
    fill(mode);
    @(negedge clk);
    run     = 1'b1;
    run_cyc = cyc + 1;
    push_expected();
    max_addr = 0;
    for (int t = 0; t < PER * G_N + 4; t++) begin
      @(negedge clk);
      if (t == 0) run = 1'b0;
      if (pulse && t == 99) run = 1'b1;
      if (pulse && t == 100) run = 1'b0;
      if (t == abort_at) begin
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_reset_mid_run");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < PER * G_N; k++) begin
          @(negedge clk);
          if (busy) begin
            check("busy_after_abort", busy, 0);
            break;
          end
        end
        check("no_valid_after_abort", sb.size(), 0);
        return;
      end
      if (chk_addr && t < PER * G_N) begin
        int off = t % PER;
        int el  = (off > N_IN - 1) ? N_IN - 1 : off;
        check("rom_addr", rom_addr, (t / PER) * N_IN + el);
        check("x_addr", x_addr, el);
        if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      end
      if (t < PER * G_N) check("busy_high", busy, 1);
      else if (t == PER * G_N) check("busy_low_after_done", busy, 0);
    end
    if (chk_addr) check("max_rom_addr", max_addr, N_IN * G_N - 1);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_release", busy, 0);

    run_pass(0, 1'b1, 1'b0, -1);   // unity
    run_pass(1, 1'b0, 1'b0, -1);   // lane independence
    run_pass(2, 1'b0, 1'b0, -1);   // negative saturation
    run_pass(3, 1'b0, 1'b0, -1);   // positive saturation
    run_pass(4, 1'b1, 1'b1, -1);   // random, run pulsed while busy
    run_pass(4, 1'b0, 1'b0, 300);  // reset mid-pass
    run_pass(0, 1'b1, 1'b0, -1);   // restart after reset
    run_pass(4, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_mac.md
# dense_mac

Sequencer and multiply-accumulate engine for one fully connected layer. It is the consumer stage directly downstream of `dense_rom`: it drives the weight ROM address and the input-vector buffer address, and accumulates six output neurons in parallel from each 96-bit ROM word. After each group of six neurons it emits the rescaled, saturated 16-bit results, one group per `y_valid` pulse.

## Interface
- `N_IN`, 200: input vector length, equal to the number of ROM words per output group.
- `N_OUT`, 24: output vector length; must be a multiple of `LANES`.
- `LANES`, 6: neurons computed in parallel, equal to the number of 16-bit weights per ROM word.
- `DW`, 16: data and weight width, signed fixed point.
- `FRAC`, 8: fractional bits of data and weights.
- `ACC_W`, 40: accumulator width per lane, signed.
- `ADDR_W`, 10: ROM address width; `(N_OUT/LANES)*N_IN` must be ≤ 2^ADDR_W.
- `X_AW`, 8: input buffer address width; `N_IN` must be ≤ 2^X_AW.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  start request; sampled only in IDLE.
- `rom_addr`  out  ADDR_W  registered address to `dense_rom`.
- `rom_q`  in  LANES*DW  ROM word. Lane j is `rom_q[DW*j +: DW]`. Valid one edge after the address is registered into the ROM.
- `x_addr`  out  X_AW  registered address to the input buffer.
- `x_q`  in  DW  input element. Same synchronous-read latency as the ROM.
- `busy`  out  1  high while not in IDLE.
- `y_valid`  out  1  one-cycle pulse; `y_data` and `y_group` are valid.
- `y_data`  out  LANES*DW  saturated results. Lane j is neuron `y_group*LANES + j`.
- `y_group`  out  log2(N_OUT/LANES), min 1  index of the emitted group.
- `done`  out  1  one-cycle pulse, coincident with the last `y_valid`.

## Operation
- States are IDLE and RUN. Reset puts the block in IDLE and zeroes all outputs, accumulators, counters and pipeline valids.
- IDLE, edge with `run=1`:
  - Load the group counter g=0 and element counter i=0.
  - Load `rom_addr=0` and `x_addr=0`.
  - Clear all accumulators and set `busy=1`. This edge is E0 of group 0.
- RUN, group g:
  - At edges E1..E(N_IN-1), i increments and the outputs become `rom_addr=g*N_IN+i`, `x_addr=i`.
  - After the last address, the addresses hold their value.
  - A 2-stage valid pipeline (v1, v2) tracks each issued address.
  - On each edge with v2=1, each lane adds `acc_j += sext(rom_q_j * x_q)`. The 32-bit signed product is sign-extended to ACC_W.
  - The last accumulation occurs at edge E(N_IN+1).
- Emit, at edge E(N_IN+2):
  - Lane result: `y_j = clamp(acc_j >>> FRAC, -32768, 32767)`, using an arithmetic shift.
  - Set `y_valid=1` and `y_group=g`.
  - Accumulators clear on the same edge.
  - If g < N_OUT/LANES-1: g increments, and this edge is also E0 of the next group. `rom_addr` becomes `(g+1)*N_IN` and `x_addr` becomes 0.
  - Otherwise: `done=1`, and the block returns to IDLE with `busy=0` on the same edge.
- `run` while busy is ignored, with no restart and no queuing.
- `rst` asserted mid-operation: all outputs return immediately to 0 and state to IDLE. Any partial group is discarded.

## Timing
- Reset values: `rom_addr=0`, `x_addr=0`, `busy=0`, `y_valid=0`, `y_data=0`, `y_group=0`, `done=0`.
- Group period is N_IN+2 cycles; with defaults, 202.
- The k-th `y_valid` (k=1..N_OUT/LANES) is k*(N_IN+2) edges after the `run` edge. With defaults, these are edges +202, +404, +606 and +808.
- `done` and the final `y_valid` occur on the same cycle.
- `busy` falls on that same edge. A `run` sampled on the next edge starts a new pass.
- `y_valid` and `done` are high for exactly one cycle. `y_data` and `y_group` hold until the next emit or reset.
- The ROM and input buffer are both synchronous-read, with one edge of latency. The block provides no other handshake or backpressure.

## Test plan
- Reset: assert `rst` asynchronously between edges. All outputs read 0 immediately. `busy=0` after release.
- Unity check, all weights `0x0100`, all x `0x0001`, defaults: each `y_valid` has every lane = `0x00C8` (200). `y_group` reads 0,1,2,3 at edges +202/+404/+606/+808. `done` fires at +808.
- Lane independence, lane j weight `j*0x0100`, x `0x0001`: lanes 0..5 read 0, 200, 400, 600, 800, 1000 (`0x03E8`) in every group.
- Saturation:
  - Weights `0x8000`, x `0x7FFF`: all lanes read `0x8000`.
  - Weights `0x7FFF`, x `0x7FFF`: all lanes read `0x7FFF`.
- Address sequence:
  - `rom_addr` steps 0..199, then 200..399, 400..599 and 600..799, changing on consecutive edges.
  - `x_addr` restarts at 0 for each group.
  - The highest `rom_addr` issued is 799.
- Control corner cases:
  - `run` pulsed at +100 while busy: the output sequence is unchanged.
  - `rst` at +300: outputs go to 0 with no further `y_valid`.
  - New `run` afterward: `y_group=0` is emitted 202 edges later.
